// File: rtl/spi_init_detector.sv
// spi_init_detector
//   Watches an SPI bus for the card-initialisation sequence: a run of
//   INIT_CYCLES dummy clocks (all chip selects high, MOSI high) followed by
//   the selection of exactly one channel. With CMD_CHECK=1, the first 48-bit
//   frame on that channel must also be CMD0 (0x400000000095).
//
// Ports
//   CLK           in   SPI clock, the only clock (rising edge)
//   reset         in   synchronous active-high reset
//   MOSI          in   master-out data, sampled on CLK rising edge
//   CS            in   [N_CS-1:0] active-low chip selects
//   IsInitialized out  [N_CS-1:0] sticky per-channel init-done flags
//   InitError     out  one-cycle pulse on a protocol violation
//   DummyCount    out  [9:0] dummy-clock count, saturating at INIT_CYCLES
module spi_init_detector #(
    parameter int INIT_CYCLES = 74,
    parameter int N_CS        = 1,
    parameter int CMD_CHECK   = 0
) (
    input  logic            CLK,
    input  logic            reset,
    input  logic            MOSI,
    input  logic [N_CS-1:0] CS,
    output logic [N_CS-1:0] IsInitialized,
    output logic            InitError,
    output logic [9:0]      DummyCount
);

    localparam int          CHW    = (N_CS > 1) ? $clog2(N_CS) : 1;
    localparam logic [9:0]  INIT_V = 10'(INIT_CYCLES);
    localparam logic [47:0] CMD0   = 48'h4000_0000_0095;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        CMD
    } state_t;

    state_t          state_q, state_d;
    logic [9:0]      dummy_q, dummy_d;
    logic [N_CS-1:0] init_q, init_d;
    logic            err_q, err_d;
    logic [47:0]     frame_q, frame_d;
    logic [5:0]      bitcnt_q, bitcnt_d;
    logic [CHW-1:0]  chan_q, chan_d;

    logic [N_CS-1:0] cs_low;
    logic [N_CS-1:0] sel;
    logic [3:0]      n_low;
    logic [CHW-1:0]  idx;
    logic [47:0]     frame_sh;

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q  <= IDLE;
            dummy_q  <= '0;
            init_q   <= '0;
            err_q    <= 1'b0;
            frame_q  <= '0;
            bitcnt_q <= '0;
            chan_q   <= '0;
        end else begin
            state_q  <= state_d;
            dummy_q  <= dummy_d;
            init_q   <= init_d;
            err_q    <= err_d;
            frame_q  <= frame_d;
            bitcnt_q <= bitcnt_d;
            chan_q   <= chan_d;
        end
    end

    always_comb begin
        cs_low = ~CS;
        n_low  = '0;
        idx    = '0;
        for (int unsigned i = 0; i < N_CS; i++) begin
            if (cs_low[i]) begin
                n_low = n_low + 4'd1;
                idx   = CHW'(i);
            end
        end
        sel      = N_CS'(1) << chan_q;
        frame_sh = {frame_q[46:0], MOSI};

        state_d  = state_q;
        dummy_d  = dummy_q;
        init_d   = init_q;
        err_d    = 1'b0;
        frame_d  = frame_q;
        bitcnt_d = bitcnt_q;
        chan_d   = chan_q;

        case (state_q)
            IDLE: begin
                if (n_low == 4'd0 && MOSI) begin
                    dummy_d = dummy_q + 10'd1;
                    if (dummy_q + 10'd1 == INIT_V) begin
                        state_d = ARMED;
                    end
                end else begin
                    dummy_d = '0;
                end
            end
            ARMED: begin
                if (n_low == 4'd0) begin
                    if (!MOSI) begin
                        state_d = IDLE;
                        dummy_d = '0;
                    end
                end else if (n_low == 4'd1) begin
                    if (CMD_CHECK == 0) begin
                        init_d  = init_q | cs_low;
                        state_d = IDLE;
                        dummy_d = '0;
                    end else begin
                        chan_d   = idx;
                        frame_d  = {47'd0, MOSI};
                        bitcnt_d = 6'd1;
                        state_d  = CMD;
                    end
                end else begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                    dummy_d = '0;
                end
            end
            CMD: begin
                // Any deviation from "only the latched channel low" aborts,
                // which covers both release of the channel and extra selects.
                if (cs_low != sel) begin
                    err_d    = 1'b1;
                    state_d  = IDLE;
                    dummy_d  = '0;
                    frame_d  = '0;
                    bitcnt_d = '0;
                end else if (bitcnt_q == 6'd47) begin
                    if (frame_sh == CMD0) begin
                        init_d = init_q | sel;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d  = IDLE;
                    dummy_d  = '0;
                    frame_d  = '0;
                    bitcnt_d = '0;
                end else begin
                    frame_d  = frame_sh;
                    bitcnt_d = bitcnt_q + 6'd1;
                end
            end
            default: begin
                state_d = IDLE;
                dummy_d = '0;
            end
        endcase
    end

    assign IsInitialized = init_q;
    assign InitError     = err_q;
    assign DummyCount    = dummy_q;

endmodule

// File: doc/spi_init_detector.md
SPI_INIT_DETECTOR -- requirements
Module: spi_init_detector

Interface
REQ-001 Parameter INIT_CYCLES, default 74: number of consecutive dummy SPI clocks (CS deasserted, MOSI high) required before a select is accepted; legal range 1..1023.
REQ-002 Parameter N_CS, default 1: number of chip-select channels; legal range 1..8.
REQ-003 Parameter CMD_CHECK, default 0: 0 = first select after arming initializes the channel; 1 = the first 48-bit frame after arming must equal CMD0 (0x40_0000_0000_95).
REQ-004 CLK  input  1  SPI clock and the only clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset, sampled on the CLK rising edge.
REQ-006 MOSI  input  1  SPI master-out data, sampled on the CLK rising edge.
REQ-007 CS  input  N_CS  active-low chip selects; bit k selects channel k.
REQ-008 IsInitialized  output  N_CS  bit k high once channel k has completed the init sequence; sticky until reset.
REQ-009 InitError  output  1  one-cycle pulse on a protocol violation (REQ-019, REQ-020).
REQ-010 DummyCount  output  10  current dummy-clock count, saturating at INIT_CYCLES.

Function
REQ-011 States IDLE, ARMED, CMD; all outputs registered.
REQ-012 IDLE, edge with all CS high and MOSI high: DummyCount += 1; when the new value equals INIT_CYCLES, go to ARMED on that edge.
REQ-013 IDLE, edge with all CS high and MOSI low: DummyCount <= 0, stay in IDLE.
REQ-014 IDLE, edge with any CS low: DummyCount <= 0, stay in IDLE, no IsInitialized change, no InitError.
REQ-015 ARMED, edge with all CS high and MOSI high: DummyCount holds at INIT_CYCLES, stay ARMED.
REQ-016 ARMED, edge with all CS high and MOSI low: go to IDLE, DummyCount <= 0.
REQ-017 ARMED, edge with exactly one CS[k] low, CMD_CHECK=0: IsInitialized[k] <= 1 on that edge (visible after that edge); go to IDLE, DummyCount <= 0.
REQ-018 ARMED, edge with exactly one CS[k] low, CMD_CHECK=1: latch channel k, capture MOSI as frame bit 47 (MSB first), bit counter <= 1, go to CMD.
REQ-019 ARMED or CMD, edge with two or more CS bits low: InitError pulse, go to IDLE, DummyCount <= 0, no IsInitialized change.
REQ-020 CMD, edge with latched CS[k] high, or with any other CS bit low, before 48 bits are captured: InitError pulse, go to IDLE, DummyCount <= 0.
REQ-021 CMD, edge with only latched CS[k] low: shift MOSI into the frame register and increment the bit counter.
REQ-022 On the edge capturing bit 48, compare the full frame with 0x400000000095. On match, IsInitialized[k] <= 1. On mismatch, InitError pulse. In both cases go to IDLE and set DummyCount <= 0.
REQ-023 Bits of IsInitialized already set are never cleared except by reset; re-initializing a set channel leaves it set and raises no error.
REQ-024 Channels are initialized one at a time; each requires its own full dummy-clock run from IDLE.
REQ-025 DummyCount never exceeds INIT_CYCLES and never wraps.

Reset
REQ-026 reset high on a CLK edge: state IDLE, DummyCount 0, IsInitialized all 0, InitError 0, frame register and bit counter 0; reset has priority over all other inputs on that edge.
REQ-027 Reset asserted mid-CMD or mid-count aborts without InitError; operation resumes from IDLE on the first edge with reset low.

Verification
REQ-028 Defaults: reset; 100 edges CS=0 MOSI=0; 40 edges CS=1 MOSI=1; 1 edge CS=0; 90 edges CS=1 MOSI=1 -> DummyCount 40, then 0, then saturates at 74; IsInitialized stays 0; InitError never pulses.
REQ-029 Defaults: 74 edges CS=1 MOSI=1, then 1 edge CS=0 -> ARMED after edge 74; IsInitialized=1 after the CS edge; DummyCount returns to 0.
REQ-030 N_CS=2, CMD_CHECK=1: 80 dummy edges, then CS=2'b10 with MOSI driving 0x400000000095 for 48 edges -> IsInitialized=2'b01 after edge 48; same run with the last byte 0x94 -> InitError pulse, IsInitialized=2'b00.
REQ-031 N_CS=2: 74 dummy edges, then CS=2'b00 -> InitError pulse, state IDLE, IsInitialized unchanged.
REQ-032 CMD_CHECK=1: CS released after 20 frame bits -> InitError pulse; reset asserted at bit 30 -> no InitError, all outputs 0 on the next edge.
REQ-033 INIT_CYCLES=4: 3 dummy edges, 1 edge MOSI=0 with CS high, 4 dummy edges -> DummyCount 3, 0, 4; ARMED only after the final run.
